// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pkg: mode encoding and timing derivations for led_pattern_gen     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package led_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] LED_OFF        = 3'd0;
  localparam logic [MODE_W-1:0] LED_ON         = 3'd1;
  localparam logic [MODE_W-1:0] LED_BLINK      = 3'd2;
  localparam logic [MODE_W-1:0] LED_BLINK_ANTI = 3'd3;
  localparam logic [MODE_W-1:0] LED_BREATHE    = 3'd4;

  function automatic int calc_ms_div(input longint clk_freq);
    longint q;
    q = clk_freq / 1000;
    return (q < 1) ? 1 : int'(q);
  endfunction

  // Clocks per duty step so that one dark-bright-dark sweep spans breathe_ms.
  function automatic int calc_step_cyc(input longint clk_freq, input longint breathe_ms,
                                       input int pwm_bits);
    longint num;
    longint den;
    longint q;
    num = (clk_freq / 1000) * breathe_ms;
    den = 2 * ((longint'(1) << pwm_bits) - 1);
    q   = num / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_timebase: shared ms / blink / PWM / breathe timers                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module led_timebase
  import led_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BLINK_MS   = 500,
  parameter int BREATHE_MS = 2000,
  parameter int PWM_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_i,
  output logic                ms_tick_o,
  output logic                blink_state_o,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic [PWM_BITS-1:0] duty_o
);

  localparam int MS_DIV   = calc_ms_div(CLK_FREQ);
  localparam int STEP_CYC = calc_step_cyc(CLK_FREQ, BREATHE_MS, PWM_BITS);
  localparam int MS_W     = width_of(MS_DIV);
  localparam int BL_W     = width_of(BLINK_MS);
  localparam int ST_W     = width_of(STEP_CYC);

  localparam logic [MS_W-1:0]     MS_LAST  = MS_W'(MS_DIV - 1);
  localparam logic [BL_W-1:0]     BL_LAST  = BL_W'(BLINK_MS - 1);
  localparam logic [ST_W-1:0]     ST_LAST  = ST_W'(STEP_CYC - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_state_q, blink_state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [ST_W-1:0]     step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;
  logic                ms_tick;

  assign ms_tick = (ms_cnt_q == MS_LAST);

  always_comb begin
    ms_cnt_d      = ms_tick ? '0 : ms_cnt_q + 1'b1;
    blink_cnt_d   = blink_cnt_q;
    blink_state_d = blink_state_q;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    step_cnt_d    = step_cnt_q + 1'b1;
    duty_d        = duty_q;
    dir_up_d      = dir_up_q;

    if (ms_tick) begin
      if (blink_cnt_q == BL_LAST) begin
        blink_cnt_d   = '0;
        blink_state_d = ~blink_state_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Direction flips on the step that lands on an end-point, so duty never wraps.
    if (step_cnt_q == ST_LAST) begin
      step_cnt_d = '0;
      if (dir_up_q) begin
        duty_d = duty_q + 1'b1;
        if (duty_d == DUTY_MAX) dir_up_d = 1'b0;
      end else begin
        duty_d = duty_q - 1'b1;
        if (duty_d == '0) dir_up_d = 1'b1;
      end
    end

    if (sync_i) begin
      ms_cnt_d      = '0;
      blink_cnt_d   = '0;
      blink_state_d = 1'b0;
      pwm_cnt_d     = '0;
      step_cnt_d    = '0;
      duty_d        = '0;
      dir_up_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt_q      <= '0;
      blink_cnt_q   <= '0;
      blink_state_q <= 1'b0;
      pwm_cnt_q     <= '0;
      step_cnt_q    <= '0;
      duty_q        <= '0;
      dir_up_q      <= 1'b1;
    end else begin
      ms_cnt_q      <= ms_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_state_q <= blink_state_d;
      pwm_cnt_q     <= pwm_cnt_d;
      step_cnt_q    <= step_cnt_d;
      duty_q        <= duty_d;
      dir_up_q      <= dir_up_d;
    end
  end

  assign ms_tick_o     = ms_tick;
  assign blink_state_o = blink_state_q;
  assign pwm_cnt_o     = pwm_cnt_q;
  assign duty_o        = duty_q;

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pattern_gen: per-channel mode-selectable LED driver               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int CHANNELS   = 6,
  parameter int BLINK_MS   = 500,
  parameter int BREATHE_MS = 2000,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int RESET_MODE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [width_of(CHANNELS)-1:0] cfg_ch,
  input  logic [MODE_W-1:0]             cfg_mode,
  input  logic                          sync_i,
  output logic [CHANNELS-1:0]           led,
  output logic                          ms_tick_o
);

  localparam int   CH_W  = width_of(CHANNELS);
  localparam logic UNLIT = (ACTIVE_LOW != 0);

  logic [CHANNELS-1:0][MODE_W-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0]             led_q, led_d;
  logic [CHANNELS-1:0]             lit;
  logic                            blink_state;
  logic [PWM_BITS-1:0]             pwm_cnt;
  logic [PWM_BITS-1:0]             duty;

  led_timebase #(
    .CLK_FREQ   (CLK_FREQ),
    .BLINK_MS   (BLINK_MS),
    .BREATHE_MS (BREATHE_MS),
    .PWM_BITS   (PWM_BITS)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_i        (sync_i),
    .ms_tick_o     (ms_tick_o),
    .blink_state_o (blink_state),
    .pwm_cnt_o     (pwm_cnt),
    .duty_o        (duty)
  );

  // Out-of-range channel indices match no entry and are dropped.
  always_comb begin
    mode_d = mode_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) mode_d[i] = cfg_mode;
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_q[i])
        LED_ON:         lit[i] = 1'b1;
        LED_BLINK:      lit[i] = blink_state;
        LED_BLINK_ANTI: lit[i] = ~blink_state;
        LED_BREATHE:    lit[i] = (pwm_cnt < duty);
        default:        lit[i] = 1'b0;
      endcase
    end
    led_d = lit ^ {CHANNELS{UNLIT}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= {CHANNELS{MODE_W'(RESET_MODE)}};
      led_q  <= {CHANNELS{UNLIT}};
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_pattern_gen: directed self-checking bench for led_pattern_gen  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_led_pattern_gen;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_mode;
  logic       sync_i;
  logic [3:0] led;
  logic       ms_tick;

  logic       cfg_we5;
  logic [2:0] cfg_ch5;
  logic [2:0] cfg_mode5;
  logic [4:0] led5;
  logic       ms_tick5;
  logic       sync5;

  int kk;
  int chk_cnt;
  int pass_cnt;

  always #5 clk = ~clk;

  // 10 kHz clock: 10 clk per ms; BREATHE_MS=12 with PWM_BITS=3 gives 8 clk per duty step.
  led_pattern_gen #(
    .CLK_FREQ(10000), .CHANNELS(4), .BLINK_MS(2), .BREATHE_MS(12),
    .PWM_BITS(3), .ACTIVE_LOW(1), .RESET_MODE(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .sync_i(sync_i), .led(led), .ms_tick_o(ms_tick)
  );

  led_pattern_gen #(
    .CLK_FREQ(10000), .CHANNELS(5), .BLINK_MS(2), .BREATHE_MS(12),
    .PWM_BITS(3), .ACTIVE_LOW(0), .RESET_MODE(0)
  ) u_dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5),
    .cfg_mode(cfg_mode5), .sync_i(sync5), .led(led5), .ms_tick_o(ms_tick5)
  );

  typedef struct {
    int         k;
    logic [3:0] led;
    logic       tick;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
    kk++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (k=%0d): got %0h expected %0h", nm, kk, act, exp);
  endtask

  // Pin level of a BLINK channel (active-low) after k edges since reset/sync, k>=1.
  function automatic logic exp_blink(input int k);
    return ((((k - 1) / 20) % 2) == 1) ? 1'b0 : 1'b1;
  endfunction

  // Duty after n completed 8-clk steps: 0,1..7,6..1, period 14.
  function automatic int tri_duty(input int n);
    int m;
    m = n % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  initial begin
    int n;
    int t;
    int c3;
    int c11;
    logic e;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; sync_i = 1'b0;
    cfg_we5 = 1'b0; cfg_ch5 = '0; cfg_mode5 = '0; sync5 = 1'b0;
    kk = 0; chk_cnt = 0; pass_cnt = 0;

    vt[0]  = '{0,  4'b1111, 1'b0};
    vt[1]  = '{9,  4'b1111, 1'b1};
    vt[2]  = '{10, 4'b1111, 1'b0};
    vt[3]  = '{19, 4'b1111, 1'b1};
    vt[4]  = '{20, 4'b1111, 1'b0};
    vt[5]  = '{21, 4'b0000, 1'b0};
    vt[6]  = '{29, 4'b0000, 1'b1};
    vt[7]  = '{39, 4'b0000, 1'b1};
    vt[8]  = '{40, 4'b0000, 1'b0};
    vt[9]  = '{41, 4'b1111, 1'b0};
    vt[10] = '{60, 4'b1111, 1'b0};
    vt[11] = '{61, 4'b0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'hF);
    chk("rst_led5", 32'(led5), 32'h0);
    chk("rst_tick", 32'(ms_tick), 32'h0);
    rst_n = 1'b1;
    kk = 0;

    // Blink timing after reset release
    for (int i = 0; i < 12; i++) begin
      while (kk < vt[i].k) step();
      chk("t1_led", 32'(led), 32'(vt[i].led));
      chk("t1_tick", 32'(ms_tick), 32'(vt[i].tick));
    end

    // Out-of-range channel writes on the 5-channel, active-high instance
    cfg_we5 = 1'b1;
    cfg_mode5 = LED_ON;
    for (int c = 5; c < 8; c++) begin
      cfg_ch5 = 3'(c);
      step();
      chk("t3_oob", 32'(led5), 32'h0);
    end
    cfg_we5 = 1'b0;
    step();
    step();
    chk("t3_oob_settled", 32'(led5), 32'h0);
    cfg_we5 = 1'b1; cfg_ch5 = 3'd4; cfg_mode5 = LED_ON;
    step();
    cfg_we5 = 1'b0;
    chk("t3_ch4_lat1", 32'(led5), 32'h0);
    step();
    chk("t3_ch4_on", 32'(led5), 32'h10);
    cfg_we5 = 1'b1; cfg_mode5 = 3'd5;
    step();
    cfg_we5 = 1'b0;
    step();
    chk("t3_reserved", 32'(led5), 32'h0);

    // Mode writes with 2-edge latency
    n = 0;
    while (!(exp_blink(kk + 1) && exp_blink(kk + 2)) && n < 100) begin
      step();
      n++;
    end
    chk("t2_wait", 32'(n < 100), 32'h1);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = LED_ON;
    step();
    cfg_we = 1'b0;
    chk("t2_lat1", 32'(led[1]), 32'(exp_blink(kk)));
    step();
    chk("t2_lat2", 32'(led[1]), 32'h0);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = LED_OFF;
    step();
    cfg_ch = 2'd3; cfg_mode = LED_BLINK_ANTI;
    step();
    cfg_we = 1'b0;
    step();
    for (int i = 0; i < 50; i++) begin
      step();
      e = exp_blink(kk);
      chk("t2_led", 32'(led), 32'({~e, 1'b1, 1'b0, e}));
    end

    // sync_i mid lit-phase together with a write to ch2
    n = 0;
    while ((kk % 40) != 33 && n < 100) begin
      step();
      n++;
    end
    chk("t5_wait", 32'(n < 100), 32'h1);
    sync_i = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = LED_BLINK_ANTI;
    step();
    kk = 0;
    sync_i = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      e = exp_blink(kk);
      chk("t5_tick", 32'(ms_tick), 32'((kk % 10) == 9));
      chk("t5_led", 32'(led), 32'({~e, ~e, 1'b0, e}));
    end

    // Breathe on ch0, aligned by a sync in the same cycle
    sync_i = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = LED_BREATHE;
    step();
    kk = 0;
    sync_i = 1'b0; cfg_we = 1'b0;
    c3 = 0;
    c11 = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      t = kk - 1;
      chk("t4_breathe", 32'(led[0]), 32'(((t % 8) < tri_duty(t / 8)) ? 1'b0 : 1'b1));
      if ((t / 8) == 3 && led[0] == 1'b0) c3++;
      if ((t / 8) == 11 && led[0] == 1'b0) c11++;
    end
    chk("t4_duty3_up", 32'(c3), 32'd3);
    chk("t4_duty3_down", 32'(c11), 32'd3);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_led", 32'(led), 32'hF);
    chk("t6_async_tick", 32'(ms_tick), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    kk = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      e = exp_blink(kk);
      chk("t6_modes_blink", 32'(led), 32'({e, e, e, e}));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
